// File: rtl/mult_div_unit_pkg.sv
// ----------------------------------------------------------------------------
// mult_div_unit_pkg
// Shared definitions for the multicycle multiply/divide unit and the control
// unit that drives it.
//   WIDTH_DEFAULT : default operand width
//   state_t       : internal sequencer states (IDLE, MULT, DIV, FIN, DZERO)
//   start_t       : decoded start request; START_MULT / START_DIV line up with
//                   the control unit's ST_MULT / ST_DIV states
//   decode_start  : start-pulse decode, multiply has priority over divide
// ----------------------------------------------------------------------------
package mult_div_unit_pkg;

   localparam int WIDTH_DEFAULT = 32;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      MULT  = 3'd1,
      DIV   = 3'd2,
      FIN   = 3'd3,
      DZERO = 3'd4
   } state_t;

   typedef enum logic [1:0] {
      START_NONE = 2'd0,
      START_MULT = 2'd1,
      START_DIV  = 2'd2
   } start_t;

   // Both pulses high in the same cycle resolves to a multiply.
   function automatic start_t decode_start(input logic start_mult,
                                           input logic start_div);
      if (start_mult)
         return START_MULT;
      else if (start_div)
         return START_DIV;
      else
         return START_NONE;
   endfunction

endpackage

// File: rtl/mult_div_unit_booth_step.sv
// ----------------------------------------------------------------------------
// booth_step
// One radix-2 Booth iteration on the {acc, q, q_1} register pair.
//   acc      : signed partial product, WIDTH+1 bits so that subtracting the
//              most negative multiplicand cannot overflow
//   q        : multiplier / low product bits
//   q_1      : previously shifted-out multiplier bit
//   m        : signed multiplicand
//   acc_next, q_next, q_1_next : register contents after add/sub and an
//              arithmetic right shift of the whole {acc, q, q_1} chain
// ----------------------------------------------------------------------------
module booth_step
   import mult_div_unit_pkg::*;
#(
   parameter int WIDTH = WIDTH_DEFAULT
) (
   input  logic signed [WIDTH:0]   acc,
   input  logic        [WIDTH-1:0] q,
   input  logic                    q_1,
   input  logic signed [WIDTH-1:0] m,
   output logic signed [WIDTH:0]   acc_next,
   output logic        [WIDTH-1:0] q_next,
   output logic                    q_1_next
);

   logic signed [WIDTH:0] m_ext;
   logic signed [WIDTH:0] sum;

   always_comb begin
      m_ext = {m[WIDTH-1], m};
      sum   = acc;
      unique case ({q[0], q_1})
         2'b01:   sum = acc + m_ext;
         2'b10:   sum = acc - m_ext;
         default: sum = acc;
      endcase
      acc_next = {sum[WIDTH], sum[WIDTH:1]};
      q_next   = {sum[0], q[WIDTH-1:1]};
      q_1_next = q[0];
   end

endmodule

// File: rtl/mult_div_unit.sv
// ----------------------------------------------------------------------------
// mult_div_unit
// Multicycle signed multiply / divide responder for the multicycle datapath.
// Multiply uses radix-2 Booth (booth_step), divide uses restoring division on
// operand magnitudes with a sign fix-up on the final step. Results appear on
// hi/lo together with a one-cycle done pulse ITER+1 cycles after acceptance.
//   clk        : clock
//   reset      : synchronous, active-high reset (aborts any operation)
//   start_mult : pulse, begin signed a*b (wins if both starts are high)
//   start_div  : pulse, begin signed a/b
//   a, b       : operands, captured on the accepting edge
//   hi         : mult upper product / div remainder (sign of a)
//   lo         : mult lower product / div quotient (truncated toward zero)
//   busy       : high in every state except IDLE
//   done       : one-cycle pulse, hi/lo valid
//   div_zero   : one-cycle pulse alongside done when the divisor was zero
// ----------------------------------------------------------------------------
module mult_div_unit
   import mult_div_unit_pkg::*;
#(
   parameter int WIDTH = WIDTH_DEFAULT,
   parameter int ITER  = WIDTH
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start_mult,
   input  logic             start_div,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo,
   output logic             busy,
   output logic             done,
   output logic             div_zero
);

   localparam int CNT_W = $clog2(ITER + 1);

   // Magnitude of a signed operand; the most negative value maps to 2^(W-1),
   // which still fits the unsigned result.
   function automatic logic [WIDTH-1:0] abs_val(input logic signed [WIDTH-1:0] x);
      if (x[WIDTH-1])
         return -x;
      else
         return x;
   endfunction

   function automatic logic [WIDTH-1:0] apply_sign(input logic [WIDTH-1:0] mag,
                                                   input logic             neg);
      if (neg)
         return -mag;
      else
         return mag;
   endfunction

   state_t             state;
   logic [CNT_W-1:0]   counter;
   logic               last_step;

   // Booth datapath
   logic signed [WIDTH:0]   acc;
   logic        [WIDTH-1:0] q;
   logic                    q_1;
   logic signed [WIDTH-1:0] m;
   logic signed [WIDTH:0]   acc_next;
   logic        [WIDTH-1:0] q_next;
   logic                    q_1_next;

   // Restoring divide datapath
   logic [WIDTH-1:0] rem;
   logic [WIDTH-1:0] quo;
   logic [WIDTH-1:0] dvs;
   logic             neg_q;
   logic             neg_r;
   logic [WIDTH:0]   shifted;
   logic [WIDTH:0]   diff;
   logic [WIDTH-1:0] rem_next;
   logic [WIDTH-1:0] quo_next;
   logic [WIDTH-1:0] rem_fix;
   logic [WIDTH-1:0] quo_fix;

   assign last_step = (counter == CNT_W'(ITER - 1));

   booth_step #(
      .WIDTH (WIDTH)
   ) u_booth_step (
      .acc      (acc),
      .q        (q),
      .q_1      (q_1),
      .m        (m),
      .acc_next (acc_next),
      .q_next   (q_next),
      .q_1_next (q_1_next)
   );

   // Shift in the next dividend bit and keep the difference only if it does
   // not borrow; the quotient bit is the inverted borrow.
   always_comb begin
      shifted  = {rem, quo[WIDTH-1]};
      diff     = shifted - {1'b0, dvs};
      rem_next = shifted[WIDTH-1:0];
      quo_next = {quo[WIDTH-2:0], 1'b0};
      if (!diff[WIDTH]) begin
         rem_next = diff[WIDTH-1:0];
         quo_next = {quo[WIDTH-2:0], 1'b1};
      end
      quo_fix = apply_sign(quo_next, neg_q);
      rem_fix = apply_sign(rem_next, neg_r);
   end

   // Operand capture / iteration: operands are reloaded every IDLE cycle, so
   // the values present on the accepting edge are the ones kept.
   always_ff @(posedge clk) begin
      unique case (state)
         IDLE: begin
            acc   <= '0;
            q     <= b;
            q_1   <= 1'b0;
            m     <= a;
            rem   <= '0;
            quo   <= abs_val(a);
            dvs   <= abs_val(b);
            neg_q <= a[WIDTH-1] ^ b[WIDTH-1];
            neg_r <= a[WIDTH-1];
         end
         MULT: begin
            acc <= acc_next;
            q   <= q_next;
            q_1 <= q_1_next;
         end
         DIV: begin
            rem <= rem_next;
            quo <= quo_next;
         end
         default: ;
      endcase
   end

   // Sequencer with registered outputs
   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= IDLE;
         counter  <= '0;
         hi       <= '0;
         lo       <= '0;
         busy     <= 1'b0;
         done     <= 1'b0;
         div_zero <= 1'b0;
      end else begin
         unique case (state)
            IDLE: begin
               done     <= 1'b0;
               div_zero <= 1'b0;
               counter  <= '0;
               unique case (decode_start(start_mult, start_div))
                  START_MULT: begin
                     state <= MULT;
                     busy  <= 1'b1;
                  end
                  START_DIV: begin
                     busy <= 1'b1;
                     if (b == '0) begin
                        state    <= DZERO;
                        done     <= 1'b1;
                        div_zero <= 1'b1;
                     end else begin
                        state <= DIV;
                     end
                  end
                  default: ;
               endcase
            end
            MULT: begin
               counter <= counter + CNT_W'(1);
               if (last_step) begin
                  state <= FIN;
                  done  <= 1'b1;
                  hi    <= acc_next[WIDTH-1:0];
                  lo    <= q_next;
               end
            end
            DIV: begin
               counter <= counter + CNT_W'(1);
               if (last_step) begin
                  state <= FIN;
                  done  <= 1'b1;
                  hi    <= rem_fix;
                  lo    <= quo_fix;
               end
            end
            FIN: begin
               state <= IDLE;
               done  <= 1'b0;
               busy  <= 1'b0;
            end
            DZERO: begin
               state    <= IDLE;
               done     <= 1'b0;
               div_zero <= 1'b0;
               busy     <= 1'b0;
            end
            default: begin
               state    <= IDLE;
               done     <= 1'b0;
               div_zero <= 1'b0;
               busy     <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mult_div_unit.sv
// ----------------------------------------------------------------------------
// tb_mult_div_unit
// Directed bench for mult_div_unit with hand-computed expected values.
// Cycle numbering: the edge that samples a start is cycle 0; the following
// negedge lies in cycle 1.
// ----------------------------------------------------------------------------
module tb_mult_div_unit;

   logic        clk = 1'b0;
   logic        reset;
   logic        start_mult;
   logic        start_div;
   logic [31:0] a;
   logic [31:0] b;
   logic [31:0] hi;
   logic [31:0] lo;
   logic        busy;
   logic        done;
   logic        div_zero;

   int total = 0;
   int bad   = 0;

   int first_done;
   int n_done;
   int n_busy;
   int n_dz;
   int dz_at_done;

   mult_div_unit #(
      .WIDTH (32),
      .ITER  (32)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .start_mult (start_mult),
      .start_div  (start_div),
      .a          (a),
      .b          (b),
      .hi         (hi),
      .lo         (lo),
      .busy       (busy),
      .done       (done),
      .div_zero   (div_zero)
   );

   always #5 clk = ~clk;

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish, observed=timeout required=finish");
      $fatal(1);
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Present a start request before an edge; returns right after the accepting edge.
   task automatic start_op(input logic sm, input logic sd, input logic [31:0] aa, input logic [31:0] bb);
      @(negedge clk);
      start_mult = sm;
      start_div  = sd;
      a          = aa;
      b          = bb;
      @(posedge clk);
   endtask

   // Watch ncycles cycles after acceptance. If inj_cyc > 0 a start_div with a
   // zero divisor is pulsed during that cycle.
   task automatic observe(input int ncycles, input int inj_cyc);
      first_done = -1;
      n_done     = 0;
      n_busy     = 0;
      n_dz       = 0;
      dz_at_done = 0;
      for (int c = 1; c <= ncycles; c++) begin
         @(negedge clk);
         if (c == 1 || c == inj_cyc + 1) begin
            start_mult = 1'b0;
            start_div  = 1'b0;
         end
         if (c == inj_cyc) begin
            start_div = 1'b1;
            a         = 32'd3;
            b         = 32'd0;
         end
         if (done) begin
            n_done++;
            if (first_done < 0) begin
               first_done = c;
               dz_at_done = int'(div_zero);
            end
         end
         if (busy)     n_busy++;
         if (div_zero) n_dz++;
      end
   endtask

   initial begin
      reset      = 1'b1;
      start_mult = 1'b0;
      start_div  = 1'b0;
      a          = '0;
      b          = '0;

      // Reset state
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("rst_hi",   64'(hi),       64'h0);
      check("rst_lo",   64'(lo),       64'h0);
      check("rst_busy", 64'(busy),     64'h0);
      check("rst_done", 64'(done),     64'h0);
      check("rst_dz",   64'(div_zero), 64'h0);
      reset = 1'b0;

      // 7 * -3 = -21
      start_op(1'b1, 1'b0, 32'd7, 32'hFFFF_FFFD);
      observe(36, 0);
      check("m1_done_cyc", 64'(first_done), 64'd33);
      check("m1_n_done",   64'(n_done),     64'd1);
      check("m1_n_busy",   64'(n_busy),     64'd33);
      check("m1_hi",       64'(hi),         64'hFFFF_FFFF);
      check("m1_lo",       64'(lo),         64'hFFFF_FFEB);

      // Divide by zero: flags at cycle 1, hi/lo untouched
      start_op(1'b0, 1'b1, 32'd5, 32'd0);
      observe(4, 0);
      check("dz_done_cyc", 64'(first_done), 64'd1);
      check("dz_flag",     64'(dz_at_done), 64'd1);
      check("dz_n_done",   64'(n_done),     64'd1);
      check("dz_n_busy",   64'(n_busy),     64'd1);
      check("dz_hi",       64'(hi),         64'hFFFF_FFFF);
      check("dz_lo",       64'(lo),         64'hFFFF_FFEB);

      // (-2^31) * (-2^31) = 2^62
      start_op(1'b1, 1'b0, 32'h8000_0000, 32'h8000_0000);
      observe(36, 0);
      check("m2_done_cyc", 64'(first_done), 64'd33);
      check("m2_hi",       64'(hi),         64'h4000_0000);
      check("m2_lo",       64'(lo),         64'h0000_0000);

      // -7 / 2 = -3 rem -1
      start_op(1'b0, 1'b1, 32'hFFFF_FFF9, 32'd2);
      observe(36, 0);
      check("d1_done_cyc", 64'(first_done), 64'd33);
      check("d1_dz",       64'(n_dz),       64'd0);
      check("d1_lo",       64'(lo),         64'hFFFF_FFFD);
      check("d1_hi",       64'(hi),         64'hFFFF_FFFF);

      // 100 / 7 = 14 rem 2
      start_op(1'b0, 1'b1, 32'd100, 32'd7);
      observe(36, 0);
      check("d2_lo", 64'(lo), 64'd14);
      check("d2_hi", 64'(hi), 64'd2);

      // Overflow case: -2^31 / -1
      start_op(1'b0, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
      observe(36, 0);
      check("d3_n_done", 64'(n_done), 64'd1);
      check("d3_dz",     64'(n_dz),   64'd0);
      check("d3_lo",     64'(lo),     64'h8000_0000);
      check("d3_hi",     64'(hi),     64'h0);

      // Both starts together: multiply wins (100*7=700, divide would give 14/2)
      start_op(1'b1, 1'b1, 32'd100, 32'd7);
      observe(36, 0);
      check("both_done_cyc", 64'(first_done), 64'd33);
      check("both_hi",       64'(hi),         64'h0);
      check("both_lo",       64'(lo),         64'd700);

      // start_div during a running multiply is ignored: -5 * 6 = -30
      start_op(1'b1, 1'b0, 32'hFFFF_FFFB, 32'd6);
      observe(40, 10);
      check("ign_n_done",   64'(n_done),     64'd1);
      check("ign_done_cyc", 64'(first_done), 64'd33);
      check("ign_dz",       64'(n_dz),       64'd0);
      check("ign_hi",       64'(hi),         64'hFFFF_FFFF);
      check("ign_lo",       64'(lo),         64'hFFFF_FFE2);

      // Reset at cycle 15 of a multiply: outputs clear, no done afterwards
      start_op(1'b1, 1'b0, 32'd9, 32'd9);
      n_done = 0;
      for (int c = 1; c <= 45; c++) begin
         @(negedge clk);
         if (c == 1) start_mult = 1'b0;
         if (c == 15) reset = 1'b1;
         if (c == 16) begin
            check("rst15_hi",   64'(hi),       64'h0);
            check("rst15_lo",   64'(lo),       64'h0);
            check("rst15_busy", 64'(busy),     64'h0);
            check("rst15_done", 64'(done),     64'h0);
            check("rst15_dz",   64'(div_zero), 64'h0);
            reset = 1'b0;
         end
         if (done) n_done++;
      end
      check("rst15_n_done", 64'(n_done), 64'd0);
      check("rst15_busy_end", 64'(busy), 64'h0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
